// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage definitions: instruction width, default PC width and the
// issue-slot rule, used by the fetch stage and by the decoder downstream.
package instruction_fetch_pkg;

   localparam int INSTR_W      = 16;
   localparam int PC_WIDTH_DEF = 12;
   localparam int QUEUE_DEPTH  = 2;

   // A read may start if it fits beside what is queued or in flight, counting a slot freed this cycle.
   function automatic logic can_issue(input logic [1:0] occ, input logic pop);
      return (occ <= 2'd1) || ((occ == 2'd2) && pop);
   endfunction

endpackage

// File: rtl/instruction_fetch_queue.sv
// Two-entry skid FIFO of {instr, pc}; entry 0 is always the head, and the head
// keeps its last contents when the queue drains so the outputs hold steady.
module fetch_queue
   import instruction_fetch_pkg::*;
#(
   parameter int DATA_W = INSTR_W,
   parameter int PC_W   = PC_WIDTH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic [PC_W-1:0]   push_pc_i,
   input  logic              pop_i,
   input  logic              flush_i,
   output logic [DATA_W-1:0] head_data_o,
   output logic [PC_W-1:0]   head_pc_o,
   output logic [1:0]        count_o
);

   localparam logic [1:0] FULL = 2'(QUEUE_DEPTH);

   logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
   logic [PC_W-1:0]   pc0_q, pc0_d, pc1_q, pc1_d;
   logic [1:0]        count_q, count_d;
   logic [1:0]        occ;

   always_comb begin
      occ     = count_q - {1'b0, pop_i};
      data0_d = data0_q;
      pc0_d   = pc0_q;
      data1_d = data1_q;
      pc1_d   = pc1_q;
      if (pop_i && (count_q == FULL)) begin
         data0_d = data1_q;
         pc0_d   = pc1_q;
      end
      // The incoming word lands in the first slot left free after this cycle's pop.
      if (push_i && (occ == 2'd0)) begin
         data0_d = push_data_i;
         pc0_d   = push_pc_i;
      end
      if (push_i && (occ == 2'd1)) begin
         data1_d = push_data_i;
         pc1_d   = push_pc_i;
      end
      count_d = occ + {1'b0, push_i};
      if (flush_i) count_d = 2'd0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data0_q <= '0;
         pc0_q   <= '0;
         data1_q <= '0;
         pc1_q   <= '0;
         count_q <= 2'd0;
      end else begin
         assert (!(push_i && !pop_i && (count_q == FULL)));
         data0_q <= data0_d;
         pc0_q   <= pc0_d;
         data1_q <= data1_d;
         pc1_q   <= pc1_d;
         count_q <= count_d;
      end
   end

   assign head_data_o = data0_q;
   assign head_pc_o   = pc0_q;
   assign count_o     = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues single-cycle-latency program-memory reads and
// queues returned words for the decoder; redirects flush the wrong path.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int                  PC_WIDTH     = PC_WIDTH_DEF,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic [PC_WIDTH-1:0] imem_addr,
   output logic                imem_rd,
   input  logic [INSTR_W-1:0]  imem_data,
   output logic [INSTR_W-1:0]  instr,
   output logic [PC_WIDTH-1:0] instr_pc,
   output logic                instr_valid,
   input  logic                instr_ready,
   input  logic                redirect,
   input  logic [PC_WIDTH-1:0] redirect_pc,
   input  logic                halt
);

   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
   logic                inflight_q, inflight_d;
   logic                discard_q, discard_d;
   logic [1:0]          count;
   logic [1:0]          occ;
   logic                pop, push, issue;

   assign pop   = instr_valid & instr_ready;
   assign occ   = count + {1'b0, inflight_q};
   // Redirect outranks halt and the slot check; nothing issues while reset is held.
   assign issue = rst_n & ~redirect & ~halt & can_issue(occ, pop);
   assign push  = inflight_q & ~discard_q & ~redirect;

   assign imem_rd     = issue;
   assign imem_addr   = pc_q;
   assign instr_valid = (count != 2'd0);

   always_comb begin
      pc_d          = pc_q;
      inflight_d    = issue;
      inflight_pc_d = inflight_pc_q;
      discard_d     = redirect;
      if (redirect) begin
         pc_d = redirect_pc;
      end else if (issue) begin
         pc_d          = pc_q + PC_WIDTH'(1);
         inflight_pc_d = pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q       <= RESET_VECTOR;
         inflight_q <= 1'b0;
         discard_q  <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
      end
   end

   always_ff @(posedge clk) begin
      inflight_pc_q <= inflight_pc_d;
   end

   fetch_queue #(
      .DATA_W (INSTR_W),
      .PC_W   (PC_WIDTH)
   ) u_queue (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push),
      .push_data_i (imem_data),
      .push_pc_i   (inflight_pc_q),
      .pop_i       (pop),
      .flush_i     (redirect),
      .head_data_o (instr),
      .head_pc_o   (instr_pc),
      .count_o     (count)
   );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: streaming, backpressure, redirects,
// halt, PC wrap (narrow instance) and reset while a fetch is outstanding.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] imem_addr;
   logic        imem_rd;
   logic [15:0] imem_data;
   logic [15:0] instr;
   logic [11:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [11:0] redirect_pc;
   logic        halt;

   logic        rst4_n;
   logic [3:0]  imem_addr4;
   logic        imem_rd4;
   logic [15:0] imem_data4;
   logic [15:0] instr4;
   logic [3:0]  instr_pc4;
   logic        instr_valid4;

   int tests = 0;
   int fails = 0;
   int exp_pc = 0;

   always #5 clk = ~clk;

   instruction_fetch #(.PC_WIDTH(12), .RESET_VECTOR(12'h000)) dut (
      .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rd(imem_rd),
      .imem_data(imem_data), .instr(instr), .instr_pc(instr_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .redirect(redirect),
      .redirect_pc(redirect_pc), .halt(halt)
   );

   instruction_fetch #(.PC_WIDTH(4), .RESET_VECTOR(4'hE)) dut4 (
      .clk(clk), .rst_n(rst4_n), .imem_addr(imem_addr4), .imem_rd(imem_rd4),
      .imem_data(imem_data4), .instr(instr4), .instr_pc(instr_pc4),
      .instr_valid(instr_valid4), .instr_ready(1'b1), .redirect(1'b0),
      .redirect_pc(4'h0), .halt(1'b0)
   );

   // Program memory: word[a] = 0x1000 + a, one-cycle latency; 0xDEAD when not read.
   always @(posedge clk) begin
      imem_data  <= imem_rd  ? (16'h1000 + {4'h0, imem_addr})   : 16'hDEAD;
      imem_data4 <= imem_rd4 ? (16'h1000 + {12'h000, imem_addr4}) : 16'hDEAD;
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rst4_n = 1'b0; instr_ready = 1'b1;
      redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
      next(); next(); #1;
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
      tests++; if (instr !== 16'h0) begin fails++; $display("FAIL reset_instr got=%h exp=0000", instr); end
      tests++; if (instr_pc !== 12'h0) begin fails++; $display("FAIL reset_instr_pc got=%h exp=000", instr_pc); end
      tests++; if (imem_rd !== 1'b0) begin fails++; $display("FAIL reset_imem_rd got=%b exp=0", imem_rd); end
      tests++; if (imem_addr !== 12'h0) begin fails++; $display("FAIL reset_imem_addr got=%h exp=000", imem_addr); end
   endtask

   // Cycle 0 is the cycle right after the last reset edge.
   task automatic test_stream();
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) next();
         #1;
         tests++; if (imem_rd !== 1'b1 || imem_addr !== 12'(c)) begin fails++; $display("FAIL stream_issue c=%0d got rd=%b addr=%h exp rd=1 addr=%h", c, imem_rd, imem_addr, 12'(c)); end
         tests++; if (instr_valid !== (c >= 2)) begin fails++; $display("FAIL stream_valid c=%0d got=%b exp=%b", c, instr_valid, (c >= 2)); end
         if (c >= 2) begin
            tests++; if (instr_pc !== 12'(c - 2) || instr !== 16'(16'h1000 + c - 2)) begin fails++; $display("FAIL stream_data c=%0d got pc=%h instr=%h exp pc=%h instr=%h", c, instr_pc, instr, 12'(c - 2), 16'(16'h1000 + c - 2)); end
         end
      end
      exp_pc = 10;
   endtask

   task automatic test_backpressure();
      next(); instr_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) next();
         #1;
         tests++; if (imem_rd !== 1'b0) begin fails++; $display("FAIL bp_no_issue k=%0d got rd=%b exp=0", k, imem_rd); end
         tests++; if (instr_valid !== 1'b1 || instr_pc !== 12'(exp_pc)) begin fails++; $display("FAIL bp_hold k=%0d got v=%b pc=%h exp v=1 pc=%h", k, instr_valid, instr_pc, 12'(exp_pc)); end
      end
      next(); instr_ready = 1'b1; #1;
      tests++; if (imem_rd !== 1'b1 || imem_addr !== 12'(exp_pc + 2)) begin fails++; $display("FAIL bp_resume got rd=%b addr=%h exp rd=1 addr=%h", imem_rd, imem_addr, 12'(exp_pc + 2)); end
      for (int k = 0; k < 6; k++) begin
         if (k > 0) next();
         #1;
         tests++; if (instr_valid !== 1'b1 || instr_pc !== 12'(exp_pc) || instr !== 16'(16'h1000 + exp_pc)) begin fails++; $display("FAIL bp_stream k=%0d got v=%b pc=%h instr=%h exp pc=%h", k, instr_valid, instr_pc, instr, 12'(exp_pc)); end
         exp_pc++;
      end
   endtask

   task automatic test_redirect();
      next(); instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 12'h080; #1;
      tests++; if (imem_rd !== 1'b0) begin fails++; $display("FAIL redir_no_issue got rd=%b exp=0", imem_rd); end
      next(); redirect = 1'b0; instr_ready = 1'b1; #1;
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL redir_r1_valid got=%b exp=0", instr_valid); end
      tests++; if (imem_rd !== 1'b1 || imem_addr !== 12'h080) begin fails++; $display("FAIL redir_r1_issue got rd=%b addr=%h exp rd=1 addr=080", imem_rd, imem_addr); end
      next(); #1;
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL redir_r2_valid got=%b exp=0", instr_valid); end
      exp_pc = 12'h080;
      for (int k = 0; k < 4; k++) begin
         next(); #1;
         tests++; if (instr_valid !== 1'b1 || instr_pc !== 12'(exp_pc) || instr !== 16'(16'h1000 + exp_pc)) begin fails++; $display("FAIL redir_stream k=%0d got v=%b pc=%h instr=%h exp pc=%h", k, instr_valid, instr_pc, instr, 12'(exp_pc)); end
         exp_pc++;
      end
   endtask

   task automatic test_back_to_back();
      next(); redirect = 1'b1; redirect_pc = 12'h200; #1;
      tests++; if (instr_valid !== 1'b1 || instr_pc !== 12'(exp_pc)) begin fails++; $display("FAIL b2b_pop_in_r got v=%b pc=%h exp v=1 pc=%h", instr_valid, instr_pc, 12'(exp_pc)); end
      next(); redirect_pc = 12'h300; #1;
      tests++; if (instr_valid !== 1'b0 || imem_rd !== 1'b0) begin fails++; $display("FAIL b2b_r1 got v=%b rd=%b exp v=0 rd=0", instr_valid, imem_rd); end
      next(); redirect = 1'b0; #1;
      tests++; if (imem_rd !== 1'b1 || imem_addr !== 12'h300) begin fails++; $display("FAIL b2b_issue got rd=%b addr=%h exp rd=1 addr=300", imem_rd, imem_addr); end
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL b2b_r2_valid got=%b exp=0", instr_valid); end
      next(); #1;
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL b2b_r3_valid got=%b exp=0", instr_valid); end
      exp_pc = 12'h300;
      for (int k = 0; k < 3; k++) begin
         next(); #1;
         tests++; if (instr_valid !== 1'b1 || instr_pc !== 12'(exp_pc) || instr !== 16'(16'h1000 + exp_pc)) begin fails++; $display("FAIL b2b_stream k=%0d got v=%b pc=%h instr=%h exp pc=%h", k, instr_valid, instr_pc, instr, 12'(exp_pc)); end
         exp_pc++;
      end
   endtask

   task automatic test_halt();
      int held;
      next(); halt = 1'b1; #1;
      tests++; if (imem_rd !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 12'(exp_pc)) begin fails++; $display("FAIL halt_h0 got rd=%b v=%b pc=%h exp rd=0 v=1 pc=%h", imem_rd, instr_valid, instr_pc, 12'(exp_pc)); end
      exp_pc++;
      next(); #1;
      tests++; if (imem_rd !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 12'(exp_pc) || instr !== 16'(16'h1000 + exp_pc)) begin fails++; $display("FAIL halt_inflight got rd=%b v=%b pc=%h instr=%h exp rd=0 v=1 pc=%h", imem_rd, instr_valid, instr_pc, instr, 12'(exp_pc)); end
      held = exp_pc;
      exp_pc++;
      next(); #1;
      tests++; if (imem_rd !== 1'b0 || instr_valid !== 1'b0 || instr_pc !== 12'(held)) begin fails++; $display("FAIL halt_empty_hold got rd=%b v=%b pc=%h exp rd=0 v=0 pc=%h", imem_rd, instr_valid, instr_pc, 12'(held)); end
      next(); halt = 1'b0; #1;
      tests++; if (imem_rd !== 1'b1 || imem_addr !== 12'(exp_pc)) begin fails++; $display("FAIL halt_resume got rd=%b addr=%h exp rd=1 addr=%h", imem_rd, imem_addr, 12'(exp_pc)); end
      next(); next(); #1;
      tests++; if (instr_valid !== 1'b1 || instr_pc !== 12'(exp_pc) || instr !== 16'(16'h1000 + exp_pc)) begin fails++; $display("FAIL halt_next got v=%b pc=%h instr=%h exp pc=%h", instr_valid, instr_pc, instr, 12'(exp_pc)); end
   endtask

   task automatic test_wrap();
      rst4_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) next();
         #1;
         tests++; if (imem_rd4 !== 1'b1 || imem_addr4 !== 4'((14 + c) % 16)) begin fails++; $display("FAIL wrap_issue c=%0d got rd=%b addr=%h exp addr=%h", c, imem_rd4, imem_addr4, 4'((14 + c) % 16)); end
         if (c >= 2) begin
            tests++; if (instr_valid4 !== 1'b1 || instr_pc4 !== 4'((12 + c) % 16) || instr4 !== 16'(16'h1000 + ((12 + c) % 16))) begin fails++; $display("FAIL wrap_data c=%0d got v=%b pc=%h instr=%h exp pc=%h", c, instr_valid4, instr_pc4, instr4, 4'((12 + c) % 16)); end
         end
      end
   endtask

   task automatic test_reset_midfetch();
      next(); rst_n = 1'b0; #1;
      tests++; if (imem_rd !== 1'b0) begin fails++; $display("FAIL rstmid_rd got=%b exp=0", imem_rd); end
      next(); rst_n = 1'b1; #1;
      tests++; if (instr_valid !== 1'b0 || instr !== 16'h0 || instr_pc !== 12'h0) begin fails++; $display("FAIL rstmid_outputs got v=%b instr=%h pc=%h exp 0", instr_valid, instr, instr_pc); end
      tests++; if (imem_rd !== 1'b1 || imem_addr !== 12'h000) begin fails++; $display("FAIL rstmid_refetch got rd=%b addr=%h exp rd=1 addr=000", imem_rd, imem_addr); end
      next(); #1;
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rstmid_c1_valid got=%b exp=0", instr_valid); end
      next(); #1;
      tests++; if (instr_valid !== 1'b1 || instr_pc !== 12'h000 || instr !== 16'h1000) begin fails++; $display("FAIL rstmid_first got v=%b pc=%h instr=%h exp v=1 pc=000 instr=1000", instr_valid, instr_pc, instr); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_back_to_back();
      test_halt();
      test_wrap();
      test_reset_midfetch();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the 16-bit DSP pipeline, directly upstream of the instruction decoder. Holds the program counter and issues synchronous reads to program memory. Buffers returned words in a 2-entry queue and hands each 16-bit instruction, with its address, to the decoder over a valid/ready handshake. Accepts branch redirects from later stages, flushing everything fetched on the wrong path.

## Interface
- PC_WIDTH, 12: program-counter and program-memory address width.
- RESET_VECTOR, 0: first fetch address after reset.

- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- imem_addr  out  PC_WIDTH  program-memory read address; equals the PC register.
- imem_rd  out  1  read strobe; combinational from the issue condition.
- imem_data  in  16  read data; valid the cycle after imem_rd.
- instr  out  16  instruction word to the decoder (queue head).
- instr_pc  out  PC_WIDTH  address of instr.
- instr_valid  out  1  queue non-empty.
- instr_ready  in  1  decoder accepts; pop = instr_valid & instr_ready.
- redirect  in  1  branch/flush request, one cycle.
- redirect_pc  in  PC_WIDTH  target address, sampled when redirect=1.
- halt  in  1  level; suppresses new issues while high.

## Operation
- State: pc, queue (2 entries of {instr, pc}, count 0..2), inflight flag plus inflight address, discard flag.
- Issue condition: !redirect & !halt & ((count + inflight) <= 1 | ((count + inflight) == 2 & pop)).
- On issue: imem_rd=1 and imem_addr=pc. pc <= pc+1 mod 2^PC_WIDTH, wrapping max→0. inflight <= 1 and inflight address <= pc.
- Return: on the cycle after an issue, if discard=0, push {imem_data, inflight address}. Push and pop in the same cycle are allowed at any count. Push at count=2 with no pop cannot occur by construction; assert on it.
- Redirect in cycle R:
  - Queue cleared at end of R.
  - pc <= redirect_pc.
  - No issue in R.
  - A word returning in R is dropped.
  - A pop in R completes normally; the decoder keeps that instruction.
- Redirect has priority over halt and over the issue condition.
- Halt: words already in flight still return and are pushed; pc holds; on deassert, issue resumes the same cycle if the issue condition holds.
- Reset (rst_n=0 at a rising edge, any time including mid-fetch):
  - pc=RESET_VECTOR, count=0, inflight=0, discard=0.
  - Outputs: instr=0, instr_pc=0, instr_valid=0, imem_rd=0, imem_addr=RESET_VECTOR.
  - A read outstanding across reset is ignored.
- instr/instr_pc hold their value when the queue is empty; they read 0 after reset until the first push.

## Timing
- First cycle after reset release (cycle 0): issue at RESET_VECTOR. Data on imem_data in cycle 1. instr_valid=1 in cycle 2.
- Steady state with instr_ready held high: one instruction per cycle, consecutive addresses, no bubbles.
- Backpressure: with instr_ready=0, issues stop once count+inflight=2. No word is lost or duplicated.
- Redirect in R: instr_valid=0 in R+1. Issue at redirect_pc in R+1. That instruction is valid in R+3, giving a 2-cycle bubble.
- Back-to-back redirects in R and R+1: the last target wins; nothing from the first target is ever presented.
- Queue output is combinational from storage; imem_rd is combinational from the issue condition. No other combinational input-to-output paths.

## Structure
- Shared package: INSTR_W=16 and the default PC_WIDTH, for use by the decoder and later stages.
- Sub-module fetch_queue: 2-entry FIFO of {instr, pc}, with push, pop, flush and count. It is the same shape as other small skid buffers in the pipeline.
- Top level holds pc, the inflight/discard tracking, the issue logic and redirect priority.

## Test plan
- Reset release, instr_ready=1, memory word[i]=0x1000+i: instr_valid rises in cycle 2. Stream 0x1000,0x1001,… with instr_pc 0,1,2,… at one per cycle.
- instr_ready low for 5 cycles mid-stream: imem_rd drops once 2 are held/in flight. After release the sequence continues with no gap, loss or duplicate.
- redirect with redirect_pc=0x080 while the queue is full and a read is outstanding: no stale word is presented. Next valid is instr_pc=0x080, exactly 3 cycles after the redirect cycle.
- PC_WIDTH=4, start at 0xE: fetch order 0xE,0xF,0x0,0x1, with instr_pc wrapping correctly.
- halt raised for 3 cycles with one read in flight: that word is still delivered, no new imem_rd occurs, and fetch resumes at the next sequential address.
- rst_n low for one cycle with the queue full and a read in flight: all outputs return to reset values. Refetch starts at RESET_VECTOR and the pre-reset word is never presented.
